// File: rtl/scan_test_controller.sv
// Sequences one scan test of the multiplier chain: shift stimulus in, capture, shift the
// product out, compare against the expected value and keep saturating pass/fail tallies.
module scan_test_controller #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] vec,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 scan_in,
  output logic                 scan_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] result,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);
  localparam int            BW   = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

  typedef struct packed {
    logic [CHAIN_LEN-1:0] vec;
    logic [CHAIN_LEN-1:0] expected;
  } req_t;

  state_t               state;
  req_t                 req_q;
  logic [BW-1:0]        bit_cnt;
  logic [CHAIN_LEN-1:0] result_nxt;

  // The last shift-out bit lands in the same edge that decides pass, so compare the merged value.
  always_comb begin
    result_nxt          = result;
    result_nxt[bit_cnt] = scan_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      bit_cnt  <= '0;
      scan_in  <= 1'b0;
      scan_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      result   <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT_IN;
            req_q   <= '{vec: vec, expected: expected};
            bit_cnt <= '0;
            scan_en <= 1'b1;
            scan_in <= vec[0];
            busy    <= 1'b1;
            pass    <= 1'b0;
            result  <= '0;
          end
        end
        SHIFT_IN: begin
          if (bit_cnt == LAST) begin
            state   <= CAPTURE;
            bit_cnt <= '0;
            scan_en <= 1'b0;
            scan_in <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
            scan_in <= req_q.vec[bit_cnt + BW'(1)];
          end
        end
        CAPTURE: begin
          state   <= SHIFT_OUT;
          bit_cnt <= '0;
          scan_en <= 1'b1;
          scan_in <= 1'b0;
        end
        SHIFT_OUT: begin
          result <= result_nxt;
          if (bit_cnt == LAST) begin
            state   <= DONE;
            bit_cnt <= '0;
            scan_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (result_nxt == req_q.expected);
            if (result_nxt == req_q.expected) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          bit_cnt <= '0;
          done    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          scan_en <= 1'b0;
          scan_in <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: a behavioural 4x4 multiplier scan chain plus a
// cycle-numbered reference of the expected scan protocol and tallies.
module tb_scan_test_controller;
  logic       clk = 1'b0;
  logic       rst, start, scan_out;
  logic [7:0] vec, expected;
  logic       scan_in, scan_en, busy, done, pass;
  logic [7:0] result, pass_cnt, fail_cnt;

  int checks = 0;
  int errors = 0;
  int exp_pass_cnt = 0;
  int exp_fail_cnt = 0;

  scan_test_controller #(.CHAIN_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .expected(expected),
    .scan_out(scan_out), .scan_in(scan_in), .scan_en(scan_en), .busy(busy),
    .done(done), .pass(pass), .result(result), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier chain: shift right with scan_in entering the MSB, or capture a*b.
  logic [7:0] chain = 8'h00;
  always @(posedge clk) begin
    if (scan_en) chain <= {scan_in, chain[7:1]};
    else         chain <= {4'h0, chain[7:4]} * {4'h0, chain[3:0]};
  end
  assign scan_out = chain[0];

  function automatic logic [7:0] mul(input logic [7:0] v);
    int a, b;
    a = v / 16;
    b = v % 16;
    return 8'(a * b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Full test from the IDLE cycle where start is raised; returns in the IDLE cycle after DONE.
  task automatic run_test(input logic [7:0] v, input logic [7:0] e);
    logic [7:0] want;
    logic       want_pass;
    want      = mul(v);
    want_pass = (want == e);
    start = 1'b1; vec = v; expected = e;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("shin_en", scan_en, 1);
      chk("shin_bit", scan_in, v[k]);
      chk("shin_busy", busy, 1);
      vec = 8'($urandom); expected = 8'($urandom); start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("cap_en", scan_en, 0);
    chk("cap_in", scan_in, 0);
    chk("cap_busy", busy, 1);
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("out_en", scan_en, 1);
      chk("out_in", scan_in, 0);
      chk("out_busy", busy, 1);
      chk("out_done", done, 0);
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (want_pass) begin if (exp_pass_cnt < 255) exp_pass_cnt++; end
    else begin if (exp_fail_cnt < 255) exp_fail_cnt++; end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_en", scan_en, 0);
    chk("result", result, want);
    chk("pass", pass, want_pass);
    chk("pass_cnt", pass_cnt, exp_pass_cnt);
    chk("fail_cnt", fail_cnt, exp_fail_cnt);
    start = 1'b1;  // must be ignored in DONE
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_en", scan_en, 0);
    chk("hold_result", result, want);
    chk("hold_pass", pass, want_pass);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] v, e;
    rst = 1'b1; start = 1'b1; vec = 8'h35; expected = 8'h0F;
    repeat (2) @(negedge clk);
    chk("rst_scan_en", scan_en, 0);
    chk("rst_scan_in", scan_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_result", result, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_en", scan_en, 0);

    run_test(8'h35, 8'h0F);
    run_test(8'hFF, 8'hE0);
    run_test(8'h00, 8'h00);
    run_test(8'hF1, 8'h0F);

    for (int i = 0; i < 24; i++) begin
      v = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? mul(v) : 8'($urandom);
      run_test(v, e);
    end

    // Reset while shifting out: at the edge ending cycle 12.
    start = 1'b1; vec = 8'hA7; expected = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_pass_cnt = 0; exp_fail_cnt = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", scan_en, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_pass_cnt", pass_cnt, 0);
    chk("mid_rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end

    run_test(8'h23, 8'h06);

    // Saturate fail_cnt; then a pass must not disturb it.
    for (int i = 0; i < 258; i++) begin
      v = 8'($urandom);
      run_test(v, mul(v) ^ 8'h01);
    end
    chk("fail_sat", fail_cnt, 8'hFF);
    run_test(8'h77, 8'h31);
    chk("pass_after_sat", pass_cnt, exp_pass_cnt);
    chk("fail_still_sat", fail_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
